wb_master: RTL

- Wishbone B4 classic single-transfer initiator that drives the UART register interface (address 0 = TX data, address 1 = RX data) from an internal command stream.
- Accepts one command at a time on a valid/ready port, runs one Wishbone cycle, and returns read data and status on a valid/ready response port.
- Sits between the host-side sequencer or command decoder and the UART register slave.

---
 rtl/wb_master_pkg.sv | 32 +++
 rtl/wb_master_if.sv | 71 +++++++
 rtl/wb_master.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/wb_master_pkg.sv
// wb_pkg: shared types and constants for the Wishbone command master and
// the sequencers and benches that talk to it through the UART register map.
package wb_pkg;

    // Master FSM states: waiting for a command, running the Wishbone
    // cycle, and holding the response until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } wb_master_state_t;

    // Default geometry of the UART register bus.
    localparam int WB_WORD_WIDTH = 8;
    localparam int WB_ADDR_WIDTH = 1;
    localparam int WB_TIMEOUT    = 15;

    // UART register map as seen from the master.
    localparam int ADDR_TX = 0;
    localparam int ADDR_RX = 1;

    // Width of a counter that must be able to hold values 0..limit.
    function automatic int wb_timer_width(input int limit);
        int width;
        width = $clog2(limit + 1);
        if (width < 1) begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/wb_master_if.sv
// wb_master_if: command port, response port and Wishbone classic bus of the
// command master bundled together. Signal names are seen from the master,
// so i_* are driven by the environment and o_* by the master.
interface wb_master_if
    import wb_pkg::*;
#(
    parameter int G_WORD_WIDTH = WB_WORD_WIDTH,
    parameter int G_ADDR_WIDTH = WB_ADDR_WIDTH
);

    // Command stream from the host-side sequencer.
    logic                    i_cmd_valid;
    logic                    o_cmd_ready;
    logic                    i_cmd_we;
    logic [G_ADDR_WIDTH-1:0] i_cmd_addr;
    logic [G_WORD_WIDTH-1:0] i_cmd_data;

    // Response stream back to the sequencer.
    logic                    o_rsp_valid;
    logic                    i_rsp_ready;
    logic [G_WORD_WIDTH-1:0] o_rsp_data;
    logic                    o_rsp_err;

    // Wishbone classic single-transfer bus towards the UART registers.
    logic                    o_cyc;
    logic                    o_stb;
    logic                    o_we;
    logic [G_ADDR_WIDTH-1:0] o_addr;
    logic [G_WORD_WIDTH-1:0] o_data;
    logic [G_WORD_WIDTH-1:0] i_data;
    logic                    i_ack;

    modport master (
        input  i_cmd_valid,
        output o_cmd_ready,
        input  i_cmd_we,
        input  i_cmd_addr,
        input  i_cmd_data,
        output o_rsp_valid,
        input  i_rsp_ready,
        output o_rsp_data,
        output o_rsp_err,
        output o_cyc,
        output o_stb,
        output o_we,
        output o_addr,
        output o_data,
        input  i_data,
        input  i_ack
    );

    modport slave (
        output i_cmd_valid,
        input  o_cmd_ready,
        output i_cmd_we,
        output i_cmd_addr,
        output i_cmd_data,
        input  o_rsp_valid,
        output i_rsp_ready,
        input  o_rsp_data,
        input  o_rsp_err,
        input  o_cyc,
        input  o_stb,
        input  o_we,
        input  o_addr,
        input  o_data,
        output i_data,
        output i_ack
    );

endinterface

// File: rtl/wb_master.sv
// wb_master: Wishbone B4 classic single-transfer initiator. Takes one command
// at a time, runs one bus cycle against the UART register slave and returns
// read data plus status on a valid/ready response port.
// Optional macro WB_MASTER_TIMEOUT_EN adds an ack timeout that aborts a
// stalled cycle after G_TIMEOUT cycles and reports it via o_rsp_err; without
// it the master waits for ack indefinitely and o_rsp_err is tied low.
module wb_master
    import wb_pkg::*;
#(
    parameter int G_WORD_WIDTH = WB_WORD_WIDTH,
    parameter int G_ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int G_TIMEOUT    = WB_TIMEOUT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    wb_master_if.master bus
);

    // A zero timeout would abort every cycle before the slave could answer.
    if (G_TIMEOUT < 1) begin : g_bad_timeout
        $error("wb_master: G_TIMEOUT must be at least 1");
    end

    wb_master_state_t        state_q, state_d;
    logic                    cyc_q, cyc_d;
    logic                    we_q, we_d;
    logic [G_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [G_WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [G_WORD_WIDTH-1:0] rsp_data_q, rsp_data_d;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TIMER_W = wb_timer_width(G_TIMEOUT);
    // The abort fires on the edge where the count would reach G_TIMEOUT,
    // so the cycle stays on the bus for exactly G_TIMEOUT REQ cycles.
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(G_TIMEOUT - 1);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               rsp_err_q, rsp_err_d;
`endif

    // Next-state and datapath decode for the IDLE -> REQ -> RESP handshake.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
`ifdef WB_MASTER_TIMEOUT_EN
        timer_d     = timer_q;
        rsp_err_d   = rsp_err_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.i_cmd_valid) begin
                    we_d    = bus.i_cmd_we;
                    addr_d  = bus.i_cmd_addr;
                    wdata_d = bus.i_cmd_data;
                    cyc_d   = 1'b1;
                    state_d = REQ;
`ifdef WB_MASTER_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end

            REQ: begin
                if (bus.i_ack) begin
                    cyc_d       = 1'b0;
                    rsp_data_d  = we_q ? '0 : bus.i_data;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
`ifdef WB_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (timer_q == TIMER_LAST) begin
                    cyc_d       = 1'b0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    timer_d     = timer_q + TIMER_W'(1);
`endif
                end
            end

            RESP: begin
                if (bus.i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and bus registers; reset drops any cycle in flight silently.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

`ifdef WB_MASTER_TIMEOUT_EN
    // Ack timeout counter and the error flag it produces.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            timer_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign bus.o_rsp_err = rsp_err_q;
`else
    assign bus.o_rsp_err = 1'b0;
`endif

    // Only single transfers are issued, so strobe always tracks cycle.
    assign bus.o_cmd_ready = (state_q == IDLE);
    assign bus.o_cyc       = cyc_q;
    assign bus.o_stb       = cyc_q;
    assign bus.o_we        = we_q;
    assign bus.o_addr      = addr_q;
    assign bus.o_data      = wdata_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_data  = rsp_data_q;

endmodule
